mult_nxn_seq: RTL and testbench
===============================

MULT_NXN_SEQ -- requirements
Module: mult_nxn_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning operand width in bits; legal values are multiples of DIGIT and at least DIGIT.
REQ-002 SHALL have parameter DIGIT, default 16, meaning the digit width multiplied per cycle; N = WIDTH/DIGIT.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port start, input, 1 bit: request a multiplication; sampled only in IDLE.
REQ-006 SHALL have port is_signed, input, 1 bit: 1 = two's-complement operands, 0 = unsigned; sampled with start.
REQ-007 SHALL have port a, input, WIDTH bits: multiplicand; sampled with start.
REQ-008 SHALL have port b, input, WIDTH bits: multiplier; sampled with start.
REQ-009 SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-010 SHALL have port done, output, 1 bit: single-cycle pulse when product is valid.
REQ-011 SHALL have port product, output, 2*WIDTH bits: registered result, held until the next done.

Function
REQ-012 SHALL implement a state machine with states IDLE, CALC and FIX.
REQ-013 IDLE with start=1: SHALL capture the operand magnitudes (|a|, |b| if is_signed, else a, b), the result sign (a[MSB] XOR b[MSB] when signed, else 0) and clear the accumulator and digit counters; next state CALC.
REQ-014 IDLE with start=0: SHALL remain in IDLE and hold product.
REQ-015 CALC: SHALL add one DIGITxDIGIT partial product per cycle, A-digit i times B-digit j, shifted left by (i+j)*DIGIT, into a 2*WIDTH accumulator.
REQ-016 CALC: j SHALL iterate fastest; the state SHALL last exactly N*N cycles, then move to FIX.
REQ-017 FIX: SHALL load product with the accumulator, two's-complement negated if the sign bit is set, pulse done for that one cycle, then return to IDLE.
REQ-018 Latency: done SHALL rise exactly N*N+2 cycles after the clock edge that samples start in IDLE; this is 6 at the defaults.
REQ-019 start while busy SHALL be ignored, with no queuing.
REQ-020 start may be asserted in the cycle after done; back-to-back throughput SHALL be one result per N*N+2 cycles.
REQ-021 Width rule: the magnitude of -2^(WIDTH-1) SHALL be representable, since operand registers are WIDTH-bit unsigned; all arithmetic SHALL be modulo 2^(2*WIDTH), with no overflow indication.
REQ-022 Operand inputs SHALL be don't-care after the sampling cycle.

Reset
REQ-023 On reset_n low: state SHALL go to IDLE; busy, done, product, accumulator and counters SHALL go to 0, regardless of the operation in progress.
REQ-024 After reset release, the first start SHALL be accepted on the first rising edge with reset_n high.

Structure
REQ-025 The shared package mult_pkg SHALL hold the state enum (IDLE, CALC, FIX) and the default WIDTH/DIGIT constants.
REQ-026 The combinational DIGITxDIGIT unsigned multiply SHALL be one sub-module, mult_digit, instantiated once.
REQ-027 Digit selection SHALL be done by index from the captured operands; no operand shifting registers.

Verification
REQ-028 Unsigned full-scale: is_signed=0, a=b=0xFFFFFFFF -> product=0xFFFFFFFE00000001, done exactly 6 cycles after start.
REQ-029 Signed mixed and negative: -3 x 5 -> 0xFFFFFFFFFFFFFFF1; -1 x -1 -> 0x0000000000000001.
REQ-030 Signed boundary: 0x80000000 x 0x80000000 -> 0x4000000000000000; 0x80000000 x 1 -> 0xFFFFFFFF80000000.
REQ-031 Busy and reset handling:
- start held high during CALC with different operands -> ignored; first result unchanged.
- reset_n low mid-CALC -> busy=0, product=0, no done; next start completes normally.
REQ-032 Parameter sweep WIDTH=64, DIGIT=16, with a scoreboard over 1000 random signed/unsigned pairs -> done after 18 cycles; all products match the reference model.

Source files
------------

// File: rtl/mult_pkg.sv
// Shared types and default sizing for the digit-serial multiplier.
package mult_pkg;

    localparam int WIDTH_DEF = 32;
    localparam int DIGIT_DEF = 16;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX
    } state_t;

endpackage

// File: rtl/mult_digit.sv
// Combinational unsigned DIGIT x DIGIT multiply.
module mult_digit #(
    parameter int DIGIT = 16
) (
    input  logic [DIGIT-1:0]   x,
    input  logic [DIGIT-1:0]   y,
    output logic [2*DIGIT-1:0] p
);

    assign p = x * y;

endmodule

// File: rtl/mult_nxn_seq.sv
// Sequential WIDTHxWIDTH multiplier: one DIGITxDIGIT partial product per cycle,
// sign handled by magnitude capture and a final negate.
module mult_nxn_seq
    import mult_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int DIGIT = DIGIT_DEF
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic               is_signed,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam int PW = 2 * WIDTH;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    state_t                  state_q, state_d;
    logic [N-1:0][DIGIT-1:0] a_q, a_d;
    logic [N-1:0][DIGIT-1:0] b_q, b_d;
    logic                    neg_q, neg_d;
    logic [CW-1:0]           i_q, i_d;
    logic [CW-1:0]           j_q, j_d;
    logic [PW-1:0]           acc_q, acc_d;
    logic [PW-1:0]           prod_q, prod_d;
    logic                    done_q, done_d;

    logic [DIGIT-1:0]   a_dig;
    logic [DIGIT-1:0]   b_dig;
    logic [2*DIGIT-1:0] pp;
    logic [PW-1:0]      pp_sh;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;

    assign a_dig = a_q[i_q];
    assign b_dig = b_q[j_q];

    mult_digit #(
        .DIGIT(DIGIT)
    ) u_digit (
        .x(a_dig),
        .y(b_dig),
        .p(pp)
    );

    always_comb begin
        pp_sh = PW'(pp) << ((int'(i_q) + int'(j_q)) * DIGIT);
        // -2^(WIDTH-1) negates to itself, which is the correct unsigned magnitude
        a_mag = (is_signed && a[WIDTH-1]) ? -a : a;
        b_mag = (is_signed && b[WIDTH-1]) ? -b : b;

        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        neg_d   = neg_q;
        i_d     = i_q;
        j_d     = j_q;
        acc_d   = acc_q;
        prod_d  = prod_q;
        done_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = a_mag;
                    b_d     = b_mag;
                    neg_d   = is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
                    acc_d   = '0;
                    i_d     = '0;
                    j_d     = '0;
                    state_d = CALC;
                end
            end
            CALC: begin
                acc_d = acc_q + pp_sh;
                if (j_q == LAST) begin
                    j_d = '0;
                    if (i_q == LAST) begin
                        state_d = FIX;
                    end else begin
                        i_d = i_q + 1'b1;
                    end
                end else begin
                    j_d = j_q + 1'b1;
                end
            end
            FIX: begin
                prod_d  = neg_q ? -acc_q : acc_q;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            neg_q   <= 1'b0;
            i_q     <= '0;
            j_q     <= '0;
            acc_q   <= '0;
            prod_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            neg_q   <= neg_d;
            i_q     <= i_d;
            j_q     <= j_d;
            acc_q   <= acc_d;
            prod_q  <= prod_d;
            done_q  <= done_d;
        end
    end

    assign busy    = (state_q != IDLE);
    assign done    = done_q;
    assign product = prod_q;

endmodule

// File: tb/tb_mult_nxn_seq.sv
// Scoreboard bench: default 32/16 instance and a 64/16 instance,
// expected products from plain wide arithmetic.
module tb_mult_nxn_seq;

    typedef struct {
        logic [127:0] exp;
        int           t;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;

    logic         start32 = 1'b0, sg32 = 1'b0;
    logic [31:0]  a32 = '0, b32 = '0;
    logic         busy32, done32;
    logic [63:0]  p32;

    logic         start64 = 1'b0, sg64 = 1'b0;
    logic [63:0]  a64 = '0, b64 = '0;
    logic         busy64, done64;
    logic [127:0] p64;

    int checks = 0;
    int fails  = 0;
    int cyc    = 0;
    exp_t q32[$];
    exp_t q64[$];

    mult_nxn_seq u32 (
        .clk(clk), .reset_n(reset_n), .start(start32), .is_signed(sg32),
        .a(a32), .b(b32), .busy(busy32), .done(done32), .product(p32)
    );

    mult_nxn_seq #(.WIDTH(64), .DIGIT(16)) u64 (
        .clk(clk), .reset_n(reset_n), .start(start64), .is_signed(sg64),
        .a(a64), .b(b64), .busy(busy64), .done(done64), .product(p64)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    function automatic void chk(input string nm, input logic [127:0] act,
                                input logic [127:0] req);
        checks++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endfunction

    // True product of the operands taken as signed or unsigned, mod 2^128
    function automatic logic [127:0] ref_mul(input logic s, input logic [63:0] x,
                                             input logic [63:0] y);
        logic [127:0] xe, ye;
        xe = s ? {{64{x[63]}}, x} : {64'b0, x};
        ye = s ? {{64{y[63]}}, y} : {64'b0, y};
        return xe * ye;
    endfunction

    function automatic logic [127:0] ref32(input logic s, input logic [31:0] x,
                                           input logic [31:0] y);
        logic [63:0]  xe, ye;
        logic [127:0] full;
        xe = s ? {{32{x[31]}}, x} : {32'b0, x};
        ye = s ? {{32{y[31]}}, y} : {32'b0, y};
        full = ref_mul(1'b1, xe, ye);
        return {64'b0, full[63:0]};
    endfunction

    // Latency = edges from the start-sampling edge to the edge that sees done
    always @(negedge clk) begin
        exp_t e;
        if (done32) begin
            if (q32.size() == 0) begin
                chk("unexpected_done32", 1'b1, 1'b0);
            end else begin
                e = q32.pop_front();
                chk("product32", {64'b0, p32}, e.exp);
                chk("latency32", cyc - e.t, 6);
            end
        end
        if (done64) begin
            if (q64.size() == 0) begin
                chk("unexpected_done64", 1'b1, 1'b0);
            end else begin
                e = q64.pop_front();
                chk("product64", p64, e.exp);
                chk("latency64", cyc - e.t, 18);
            end
        end
    end

    // Called at a negedge; returns at the negedge after done
    task automatic run_op(input bit w64, input bit s, input logic [63:0] x,
                          input logic [63:0] y, input logic [127:0] exp,
                          input bit hold);
        exp_t e;
        int   n;
        e.exp = exp;
        e.t   = cyc;
        chk("idle_busy", w64 ? busy64 : busy32, 1'b0);
        if (w64) begin
            start64 = 1'b1; sg64 = s; a64 = x; b64 = y;
            q64.push_back(e);
        end else begin
            start32 = 1'b1; sg32 = s; a32 = x[31:0]; b32 = y[31:0];
            q32.push_back(e);
        end
        @(negedge clk);
        start32 = 1'b0; start64 = 1'b0;
        a32 = $urandom; b32 = $urandom;
        a64 = {$urandom, $urandom}; b64 = {$urandom, $urandom};
        sg32 = $urandom; sg64 = $urandom;
        chk("busy_after_start", w64 ? busy64 : busy32, 1'b1);
        if (hold) begin
            if (w64) start64 = 1'b1;
            else     start32 = 1'b1;
            repeat (3) @(negedge clk);
            start32 = 1'b0; start64 = 1'b0;
        end
        n = 0;
        while (!(w64 ? done64 : done32) && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!(w64 ? done64 : done32)) chk("done_timeout", 1'b0, 1'b1);
        @(negedge clk);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        s;
        logic [63:0] x, y;
        repeat (3) @(negedge clk);
        chk("rst_busy32", busy32, 1'b0);
        chk("rst_done32", done32, 1'b0);
        chk("rst_prod32", {64'b0, p32}, 128'b0);
        chk("rst_busy64", busy64, 1'b0);
        chk("rst_prod64", p64, 128'b0);
        reset_n = 1'b1;

        run_op(0, 0, 64'hFFFFFFFF, 64'hFFFFFFFF, 128'hFFFFFFFE00000001, 0);
        run_op(0, 1, 64'hFFFFFFFD, 64'h5, 128'hFFFFFFFFFFFFFFF1, 0);
        run_op(0, 1, 64'hFFFFFFFF, 64'hFFFFFFFF, 128'h1, 0);
        run_op(0, 1, 64'h80000000, 64'h80000000, 128'h4000000000000000, 0);
        run_op(0, 1, 64'h80000000, 64'h1, 128'hFFFFFFFF80000000, 0);
        run_op(0, 0, 64'h80000000, 64'h80000000, 128'h4000000000000000, 0);
        run_op(0, 1, 64'h12345678, 64'h9ABCDEF0, ref32(1, 32'h12345678, 32'h9ABCDEF0), 1);

        // Abort mid-calculation: nothing queued, so any done is flagged
        start32 = 1'b1; sg32 = 1'b0; a32 = 32'h7; b32 = 32'h9;
        @(negedge clk);
        start32 = 1'b0;
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("midreset_busy", busy32, 1'b0);
        chk("midreset_prod", {64'b0, p32}, 128'b0);
        chk("midreset_done", done32, 1'b0);
        @(negedge clk);
        reset_n = 1'b1;
        run_op(0, 1, 64'hFFFFFFF9, 64'h9, ref32(1, 32'hFFFFFFF9, 32'h9), 0);

        for (int k = 0; k < 200; k++) begin
            s = $urandom;
            x = {32'b0, $urandom};
            y = {32'b0, ($urandom_range(0, 7) == 0) ? 32'h80000000 : $urandom};
            run_op(0, s, x, y, ref32(s, x[31:0], y[31:0]), 0);
        end

        run_op(1, 1, 64'h8000000000000000, 64'h8000000000000000,
               128'h40000000000000000000000000000000, 0);
        run_op(1, 0, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF,
               128'hFFFFFFFFFFFFFFFE0000000000000001, 0);
        for (int k = 0; k < 1000; k++) begin
            s = $urandom;
            x = {$urandom, $urandom};
            y = ($urandom_range(0, 15) == 0) ? 64'h8000000000000000
                                             : {$urandom, $urandom};
            run_op(1, s, x, y, ref_mul(s, x, y), 0);
        end

        repeat (4) @(negedge clk);
        chk("q32_drained", q32.size(), 0);
        chk("q64_drained", q64.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
